// File: rtl/card_pkg.sv
// Shared constants and state encoding for the card sprite memories, used by
// both the run-time sprite loader and the display-side pixel reader.
package card_pkg;
   localparam int CARD_W         = 32;
   localparam int CARD_H         = 46;
   localparam int PIX_PER_CARD   = CARD_W * CARD_H;
   localparam int NUM_CARD_TYPES = 54;
   localparam int SUIT_SIZE      = 13;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   localparam int MEM_BLACK      = 0;
   localparam int MEM_BLUE       = 1;
   localparam int MEM_RED        = 2;
   localparam int MEM_ORANGE     = 3;
   localparam int MEM_RED_FACE   = 4;
   localparam int MEM_BLACK_FACE = 5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TYPE,
      ST_PIX_HI,
      ST_PIX_LO,
      ST_CHK,
      ST_DONE
   } card_state_e;
endpackage

// File: rtl/card_addr_base.sv
// Card type to memory select and base address. Suit cards share a memory per
// suit (13 sprites stacked); the two face sprites each own a memory at base 0.
module card_addr_base
   import card_pkg::*;
(
   input  logic [7:0]  card_type,
   output logic        valid,
   output logic [5:0]  sel,
   output logic [14:0] base
);
   logic [3:0] rank;

   always_comb begin
      valid = 1'b1;
      sel   = '0;
      rank  = '0;
      if (card_type < 8'(SUIT_SIZE)) begin
         sel[MEM_BLACK] = 1'b1;
         rank           = card_type[3:0];
      end else if (card_type < 8'(2 * SUIT_SIZE)) begin
         sel[MEM_BLUE] = 1'b1;
         rank          = 4'(card_type - 8'(SUIT_SIZE));
      end else if (card_type < 8'(3 * SUIT_SIZE)) begin
         sel[MEM_RED] = 1'b1;
         rank         = 4'(card_type - 8'(2 * SUIT_SIZE));
      end else if (card_type < 8'(4 * SUIT_SIZE)) begin
         sel[MEM_ORANGE] = 1'b1;
         rank            = 4'(card_type - 8'(3 * SUIT_SIZE));
      end else if (card_type == 8'(4 * SUIT_SIZE)) begin
         sel[MEM_RED_FACE] = 1'b1;
      end else if (card_type == 8'(4 * SUIT_SIZE + 1)) begin
         sel[MEM_BLACK_FACE] = 1'b1;
      end else begin
         valid = 1'b0;
      end
      base = 15'(rank) * 15'(PIX_PER_CARD);
   end
endmodule

// File: rtl/card_sprite_loader.sv
// Byte-stream sprite loader: sync, card type, then 2944 pixel bytes written to
// the card memories. Define CARD_LOADER_CHECKSUM_EN for a trailing XOR check byte.
module card_sprite_loader
   import card_pkg::*;
(
   input  logic        clk_25MHz,
   input  logic        rst_n,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [5:0]  mem_we,
   output logic [14:0] mem_addr,
   output logic [11:0] mem_din,
   output logic        busy,
   output logic        done,
   output logic        err
);
   card_state_e state;
   logic [5:0]  sel;
   logic [14:0] addr;
   logic [10:0] count;
   logic [3:0]  red;
   logic        accept;

   logic        type_valid;
   logic [5:0]  type_sel;
   logic [14:0] type_base;

   assign in_ready = (state != ST_DONE);
   assign busy     = (state != ST_IDLE);
   assign accept   = in_valid && in_ready;

   card_addr_base u_addr_base (
      .card_type (in_data),
      .valid     (type_valid),
      .sel       (type_sel),
      .base      (type_base)
   );

`ifdef CARD_LOADER_CHECKSUM_EN
   logic [7:0] csum;

   // Running XOR over the type byte and every pixel byte of the frame.
   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         csum <= '0;
      end else if (accept) begin
         case (state)
            ST_TYPE:              csum <= in_data;
            ST_PIX_HI, ST_PIX_LO: csum <= csum ^ in_data;
            default:              ;
         endcase
      end
   end
`endif

   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         sel      <= '0;
         addr     <= '0;
         count    <= '0;
         red      <= '0;
         mem_we   <= '0;
         mem_addr <= '0;
         mem_din  <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         mem_we <= '0;
         done   <= 1'b0;
         err    <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept && in_data == SYNC_BYTE) state <= ST_TYPE;
            end
            ST_TYPE: begin
               if (accept) begin
                  if (type_valid) begin
                     sel   <= type_sel;
                     addr  <= type_base;
                     count <= '0;
                     state <= ST_PIX_HI;
                  end else begin
                     err   <= 1'b1;
                     state <= ST_IDLE;
                  end
               end
            end
            ST_PIX_HI: begin
               if (accept) begin
                  red   <= in_data[3:0];
                  state <= ST_PIX_LO;
               end
            end
            ST_PIX_LO: begin
               if (accept) begin
                  mem_we   <= sel;
                  mem_addr <= addr;
                  mem_din  <= {red, in_data};
                  if (count == 11'(PIX_PER_CARD - 1)) begin
`ifdef CARD_LOADER_CHECKSUM_EN
                     state <= ST_CHK;
`else
                     done  <= 1'b1;
                     state <= ST_DONE;
`endif
                  end else begin
                     count <= count + 11'd1;
                     addr  <= addr + 15'd1;
                     state <= ST_PIX_HI;
                  end
               end
            end
`ifdef CARD_LOADER_CHECKSUM_EN
            ST_CHK: begin
               if (accept) begin
                  if (in_data == csum) begin
                     done  <= 1'b1;
                     state <= ST_DONE;
                  end else begin
                     err   <= 1'b1;
                     state <= ST_IDLE;
                  end
               end
            end
`endif
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_card_sprite_loader.sv
// Randomized bench for card_sprite_loader with a byte-position reference model
// compared against every output on every cycle out of reset.
module tb_card_sprite_loader;
   logic        clk_25MHz;
   logic        rst_n;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  mem_we;
   logic [14:0] mem_addr;
   logic [11:0] mem_din;
   logic        busy;
   logic        done;
   logic        err;

   card_sprite_loader dut (
      .clk_25MHz (clk_25MHz),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_din   (mem_din),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   initial begin
      clk_25MHz = 1'b0;
      forever #20 clk_25MHz = ~clk_25MHz;
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Reference model: tracks position within the frame by byte count.
   function automatic int mem_idx(input int t);
      return (t < 52) ? t / 13 : t - 48;
   endfunction
   function automatic int base_of(input int t);
      return (t < 52) ? (t % 13) * 1472 : 0;
   endfunction

   int          pos, mtype;
   logic [3:0]  rnib;
   logic [7:0]  xsum;
   logic [5:0]  exp_we;
   logic [14:0] exp_addr;
   logic [11:0] exp_din;
   logic        exp_done, exp_err, exp_busy, exp_ready;

   task automatic model_reset();
      pos = 0; mtype = 0; rnib = '0; xsum = '0;
      exp_we = '0; exp_addr = '0; exp_din = '0;
      exp_done = 1'b0; exp_err = 1'b0; exp_busy = 1'b0; exp_ready = 1'b1;
   endtask

   task automatic model_step();
      int k, i;
      exp_we = '0; exp_done = 1'b0; exp_err = 1'b0;
      if (!exp_ready) begin
         exp_ready = 1'b1;
      end else if (in_valid) begin
         if (pos == 0) begin
            if (in_data == 8'hA5) pos = 1;
         end else if (pos == 1) begin
            if (in_data < 8'd54) begin
               mtype = int'(in_data); xsum = in_data; pos = 2;
            end else begin
               exp_err = 1'b1; pos = 0;
            end
         end else if (pos <= 2945) begin
            k = pos - 2;
            xsum = xsum ^ in_data;
            if (k % 2 == 0) begin
               rnib = in_data[3:0];
               pos++;
            end else begin
               i = k / 2;
               exp_we   = 6'(1 << mem_idx(mtype));
               exp_addr = 15'(base_of(mtype) + i);
               exp_din  = {rnib, in_data};
               if (i == 1471) begin
`ifdef CARD_LOADER_CHECKSUM_EN
                  pos = 2946;
`else
                  pos = 0; exp_done = 1'b1; exp_ready = 1'b0;
`endif
               end else begin
                  pos++;
               end
            end
         end else begin
            if (in_data == xsum) begin
               exp_done = 1'b1; exp_ready = 1'b0;
            end else begin
               exp_err = 1'b1;
            end
            pos = 0;
         end
      end
      exp_busy = (pos != 0) || !exp_ready;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk_25MHz or negedge rst_n);
         if (!rst_n) model_reset();
         else model_step();
      end
   end

   typedef struct packed {
      logic [5:0]  we;
      logic [14:0] addr;
      logic [11:0] din;
   } wr_t;
   wr_t wq[$];
   int  done_cnt = 0;
   int  err_cnt  = 0;

   // Compare process: every output against the model on the falling edge.
   initial begin
      forever begin
         @(negedge clk_25MHz);
         if (rst_n) begin
            chk("mem_we",   int'(mem_we),   int'(exp_we));
            chk("mem_addr", int'(mem_addr), int'(exp_addr));
            chk("mem_din",  int'(mem_din),  int'(exp_din));
            chk("done",     int'(done),     int'(exp_done));
            chk("err",      int'(err),      int'(exp_err));
            chk("busy",     int'(busy),     int'(exp_busy));
            chk("in_ready", int'(in_ready), int'(exp_ready));
            if (mem_we != '0) wq.push_back('{we: mem_we, addr: mem_addr, din: mem_din});
            if (done) done_cnt++;
            if (err) err_cnt++;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      int tries;
      while ($urandom_range(99) < gap) begin
         in_valid = 1'b0;
         @(posedge clk_25MHz); #1;
      end
      in_valid = 1'b1;
      in_data  = b;
      tries    = 0;
      while (!in_ready) begin
         @(posedge clk_25MHz); #1;
         tries++;
         if (tries > 8) begin
            n_checks++;
            $display("FAIL in_ready_wait: got 0 for %0d cycles expected 1", tries);
            break;
         end
      end
      @(posedge clk_25MHz); #1;
   endtask

   task automatic send_frame(input int t, input int npix, input int gap,
                             input int pat, input bit bad_chk);
      logic [7:0]  x, b;
      logic [11:0] px;
      x = 8'(t);
      send_byte(8'hA5, gap);
      send_byte(8'(t), gap);
      for (int p = 0; p < npix; p++) begin
         px = (pat == 0) ? 12'(p) : 12'($urandom);
         b  = {4'($urandom), px[11:8]};
         x  = x ^ b;
         send_byte(b, gap);
         b  = px[7:0];
         x  = x ^ b;
         send_byte(b, gap);
      end
`ifdef CARD_LOADER_CHECKSUM_EN
      if (npix == 1472) send_byte(bad_chk ? ~x : x, gap);
`else
      if (bad_chk) send_byte(8'h3C, gap);
`endif
      in_valid = 1'b0;
   endtask

   task automatic expect_frame(input int s, input int d0, input int e0, input int nw,
                               input int we, input int first, input int last,
                               input int dd, input int de);
      repeat (3) @(posedge clk_25MHz);
      #1;
      chk("write_count", wq.size() - s, nw);
      if (nw > 0 && wq.size() > s) begin
         chk("first_we",   int'(wq[s].we), we);
         chk("first_addr", int'(wq[s].addr), first);
         chk("last_addr",  int'(wq[wq.size()-1].addr), last);
      end
      chk("done_pulses", done_cnt - d0, dd);
      chk("err_pulses",  err_cnt - e0, de);
   endtask

   task automatic check_reset_values();
      chk("rst_mem_we",   int'(mem_we), 0);
      chk("rst_mem_addr", int'(mem_addr), 0);
      chk("rst_mem_din",  int'(mem_din), 0);
      chk("rst_busy",     int'(busy), 0);
      chk("rst_done",     int'(done), 0);
      chk("rst_err",      int'(err), 0);
      chk("rst_in_ready", int'(in_ready), 1);
   endtask

   initial begin
      #(40 * 95000);
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int s, d0, e0, t;
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
      repeat (3) @(posedge clk_25MHz);
      #5;
      check_reset_values();
      rst_n = 1'b1;
      @(posedge clk_25MHz); #1;

      // Type 0, pixel value = index
      s = wq.size(); d0 = done_cnt; e0 = err_cnt;
      send_frame(0, 1472, 0, 0, 1'b0);
      expect_frame(s, d0, e0, 1472, 6'b000001, 0, 1471, 1, 0);
      chk("pix100_addr", int'(wq[s+100].addr), 100);
      chk("pix100_din",  int'(wq[s+100].din), 100);
      chk("pix1471_din", int'(wq[s+1471].din), 1471);

      // Red slot 1
      s = wq.size(); d0 = done_cnt; e0 = err_cnt;
      send_frame(27, 1472, 0, 1, 1'b0);
      expect_frame(s, d0, e0, 1472, 6'b000100, 1472, 2943, 1, 0);

      // Red face
      s = wq.size(); d0 = done_cnt; e0 = err_cnt;
      send_frame(52, 1472, 0, 1, 1'b0);
      expect_frame(s, d0, e0, 1472, 6'b010000, 0, 1471, 1, 0);

      // Junk, sync, invalid type
      s = wq.size(); d0 = done_cnt; e0 = err_cnt;
      send_byte(8'h00, 0); send_byte(8'h17, 0); send_byte(8'hA5, 0); send_byte(8'd54, 0);
      in_valid = 1'b0;
      expect_frame(s, d0, e0, 0, 0, 0, 0, 0, 1);
      s = wq.size(); d0 = done_cnt; e0 = err_cnt;
      send_frame(5, 1472, 0, 1, 1'b0);
      expect_frame(s, d0, e0, 1472, 6'b000001, 7360, 8831, 1, 0);

      // Orange 12 with ~50% input gaps
      s = wq.size(); d0 = done_cnt; e0 = err_cnt;
      send_frame(51, 1472, 50, 0, 1'b0);
      expect_frame(s, d0, e0, 1472, 6'b001000, 17664, 19135, 1, 0);
      chk("gap_pix7_din", int'(wq[s+7].din), 7);

      // Black face, extra byte trails the frame
      s = wq.size(); d0 = done_cnt; e0 = err_cnt;
      send_frame(53, 1472, 10, 1, 1'b0);
      send_byte(8'h3C, 0);
      in_valid = 1'b0;
      expect_frame(s, d0, e0, 1472, 6'b100000, 0, 1471, 1, 0);

      // Reset after 700 pixels
      s = wq.size(); d0 = done_cnt; e0 = err_cnt;
      send_frame(10, 700, 0, 1, 1'b0);
      @(negedge clk_25MHz); #5;
      rst_n = 1'b0;
      #1;
      check_reset_values();
      repeat (2) @(posedge clk_25MHz);
      #5;
      rst_n = 1'b1;
      @(posedge clk_25MHz); #1;
      expect_frame(s, d0, e0, 700, 6'b000001, 14720, 15419, 0, 0);
      s = wq.size(); d0 = done_cnt; e0 = err_cnt;
      send_frame(10, 1472, 0, 1, 1'b0);
      expect_frame(s, d0, e0, 1472, 6'b000001, 14720, 16191, 1, 0);

      // Trailing byte: checksum (good then corrupted) or junk
`ifdef CARD_LOADER_CHECKSUM_EN
      s = wq.size(); d0 = done_cnt; e0 = err_cnt;
      send_frame(20, 1472, 0, 1, 1'b0);
      expect_frame(s, d0, e0, 1472, 6'b000010, 10304, 11775, 1, 0);
      s = wq.size(); d0 = done_cnt; e0 = err_cnt;
      send_frame(20, 1472, 0, 1, 1'b1);
      expect_frame(s, d0, e0, 1472, 6'b000010, 10304, 11775, 0, 1);
`else
      s = wq.size(); d0 = done_cnt; e0 = err_cnt;
      send_frame(20, 1472, 0, 1, 1'b1);
      expect_frame(s, d0, e0, 1472, 6'b000010, 10304, 11775, 1, 0);
`endif

      // Random card types
      for (int n = 0; n < 2; n++) begin
         t = int'($urandom_range(53));
         s = wq.size(); d0 = done_cnt; e0 = err_cnt;
         send_frame(t, 1472, 20, 1, 1'b0);
         expect_frame(s, d0, e0, 1472, 1 << mem_idx(t), base_of(t), base_of(t) + 1471, 1, 0);
      end

      repeat (4) @(posedge clk_25MHz);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/card_sprite_loader.md
# card_sprite_loader

Streams card artwork into the six card-pixel block memories at run time: the write-side counterpart of the card pixel reader used by the display path. Accepts a byte stream (typically from the UART receiver) framed as sync, card type, then 1472 pixels of 12-bit RGB. It drives the memory port-A write strobes, address and data so sprites can be replaced without re-synthesis.

## Interface
- CARD_W, 32, sprite width in pixels
- CARD_H, 46, sprite height in pixels
- SYNC_BYTE, 8'hA5, frame start marker
- clk_25MHz  in  1  system/pixel clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  8  stream byte
- in_valid  in  1  byte present
- in_ready  out  1  loader accepts byte this cycle
- mem_we  out  6  one-hot write enable: [0] black, [1] blue, [2] red, [3] orange, [4] red_face, [5] black_face
- mem_addr  out  15  write address, shared by all six memories
- mem_din  out  12  pixel {R[3:0],G[3:0],B[3:0]}
- busy  out  1  frame in progress (any state except IDLE)
- done  out  1  one-cycle pulse, frame fully written
- err  out  1  one-cycle pulse, frame rejected/failed

## Operation
- Byte accepted when in_valid && in_ready. in_ready = 1 in all states except DONE.
- Card type mapping: 0–12 mem 0, 13–25 mem 1, 26–38 mem 2, 39–51 mem 3, base = (type mod 13)*1472; 52 mem 4, 53 mem 5, base = 0. Type ≥ 54 invalid.
- Pixel order row-major, x fastest; pixel index i = y*32+x, 0..1471; address = base + i (max 19135).
- States:
  - IDLE: bytes ≠ SYNC_BYTE discarded silently; SYNC_BYTE → TYPE.
  - TYPE: valid type → latch mem select, addr counter = base, pixel count = 0, → PIX_HI; invalid → err pulse, → IDLE.
  - PIX_HI: latch in_data[3:0] as R (upper nibble ignored) → PIX_LO.
  - PIX_LO: in_data = {G,B}; issue write; count == 1471 → CHK (if enabled) else DONE; otherwise count++, addr++, → PIX_HI.
  - CHK: compare byte with running checksum; → DONE on match, → IDLE with err pulse on mismatch.
  - DONE: done pulse, in_ready = 0, → IDLE next cycle.
- A SYNC_BYTE value inside the payload is data; no resynchronisation mid-frame.
- Stalls (in_valid low) hold state indefinitely; no timeout.

## Timing
- Write is registered: mem_we one-hot, mem_addr, mem_din valid for exactly one cycle, the cycle after the PIX_LO byte is accepted. mem_we = 0 all other cycles.
- Full-rate stream (one byte/cycle): frame = 2 + 2944 (+1 checksum) bytes; done asserts the cycle after the last accepted byte, concurrent with DONE state.
- err asserts the cycle after the offending byte is accepted.
- Reset values: state IDLE, mem_we 0, mem_addr 0, mem_din 0, busy 0, done 0, err 0, in_ready 1.
- Reset mid-frame aborts immediately; pixels already written remain in memory; no done/err pulse.

## Configuration
- CARD_LOADER_CHECKSUM_EN defined: one trailing byte after the last pixel, equal to XOR of the type byte and all 2944 pixel bytes; CHK state present; mismatch → err (memory contents already written, not rolled back).
- Undefined: no CHK state, no trailing byte; PIX_LO of pixel 1471 → DONE.

## Structure
- Shared package card_pkg: CARD_W, CARD_H, PIX_PER_CARD (1472), NUM_CARD_TYPES (54), SUIT_SIZE (13), SYNC_BYTE, memory-index constants (MEM_BLACK..MEM_BLACK_FACE), state enum.
- One sub-module card_addr_base: combinational card type → {valid, 6-bit one-hot select, 15-bit base}; same mapping is reusable by the reader.

## Test plan
- Sync 8'hA5, type 0, 1472 pixels with value = index[11:0] → mem_we[0] 1472 pulses, addresses 0..1471, data 0..1471, done once, err never.
- Sync, type 27 (red, slot 1) → first write addr 1472 on mem_we[2], last addr 2943; type 52 → mem_we[4] addr 0..1471.
- Leading junk 8'h00, 8'h17 then sync, then type 54 → no writes, err pulse one cycle after type byte, back to IDLE, next valid frame loads normally.
- Random in_valid gaps (≈50% duty) on type 51 frame → identical write sequence to gap-free run, base 12*1472 = 17664, last addr 19135.
- Assert rst_n low after 700 pixels → outputs return to reset values asynchronously, no done; next full frame completes correctly.
- With CARD_LOADER_CHECKSUM_EN: correct checksum → done; corrupted checksum byte → err, no done; without macro, byte after last pixel is treated as junk in IDLE.
